ram_2rw_clr: RTL and testbench

RAM_2RW_CLR -- requirements
Module: ram_2rw_clr

---
 rtl/ram_2rw_clr.sv | 145 ++++++++++++++
 tb/tb_ram_2rw_clr.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_2rw_clr.sv
// Dual-port read/write RAM with byte-lane write enables, pipelined reads
// and a word-per-cycle hardware clear after reset or on request.
module ram_2rw_clr #(
  parameter int unsigned DWIDTH         = 64,
  parameter int unsigned AWIDTH         = 10,
  parameter int unsigned BWIDTH         = 8,
  parameter int unsigned RD_LAT         = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       clear_req,
  output logic                       init_done,
  input  logic                       en_a,
  input  logic                       wr_en_a,
  input  logic [AWIDTH-1:0]          address_a,
  input  logic [DWIDTH-1:0]          wr_data_a,
  input  logic [DWIDTH/BWIDTH-1:0]   be_a,
  output logic [DWIDTH-1:0]          q_a,
  output logic                       q_valid_a,
  input  logic                       en_b,
  input  logic                       wr_en_b,
  input  logic [AWIDTH-1:0]          address_b,
  input  logic [DWIDTH-1:0]          wr_data_b,
  input  logic [DWIDTH/BWIDTH-1:0]   be_b,
  output logic [DWIDTH-1:0]          q_b,
  output logic                       q_valid_b
);

  localparam int unsigned NB    = DWIDTH / BWIDTH;
  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [AWIDTH-1:0]   clear_addr, clear_addr_n;

  logic [DWIDTH-1:0]   mem [DEPTH];

  logic [1:0]          en, wr_en, rd_acc, wr_acc;
  logic [AWIDTH-1:0]   addr  [2];
  logic [DWIDTH-1:0]   wdata [2];
  logic [NB-1:0]       be    [2];

  assign en       = {en_b, en_a};
  assign wr_en    = {wr_en_b, wr_en_a};
  assign addr[0]  = address_a;
  assign addr[1]  = address_b;
  assign wdata[0] = wr_data_a;
  assign wdata[1] = wr_data_b;
  assign be[0]    = be_a;
  assign be[1]    = be_b;

  assign init_done = (state == READY);
  assign rd_acc    = {2{init_done}} & en & ~wr_en;
  assign wr_acc    = {2{init_done}} & en & wr_en;

  // State register and clear address counter
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR_ON_RESET ? CLEAR : READY;
      clear_addr <= '0;
    end else begin
      state      <= state_n;
      clear_addr <= clear_addr_n;
    end
  end

  // Next-state logic; clear_req is only honoured in READY
  always_comb begin
    state_n      = state;
    clear_addr_n = clear_addr;
    case (state)
      CLEAR: begin
        clear_addr_n = clear_addr + AWIDTH'(1);
        if (clear_addr == LAST_ADDR) begin
          state_n      = READY;
          clear_addr_n = '0;
        end
      end
      READY: begin
        if (clear_req) begin
          state_n      = CLEAR;
          clear_addr_n = '0;
        end
      end
      default: begin
        state_n      = READY;
        clear_addr_n = '0;
      end
    endcase
  end

  // Array write: port B first so port A wins on overlapping enabled lanes
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clear_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_acc[1] && be_b[i])
          mem[address_b][i*BWIDTH +: BWIDTH] <= wr_data_b[i*BWIDTH +: BWIDTH];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_acc[0] && be_a[i])
          mem[address_a][i*BWIDTH +: BWIDTH] <= wr_data_a[i*BWIDTH +: BWIDTH];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DWIDTH-1:0] pipe_d [RD_LAT];
    logic [RD_LAT-1:0] pipe_v;
    logic [DWIDTH-1:0] q_r;
    logic              qv_r;

    // Read data pipeline; stage 0 samples pre-write contents at acceptance
    always_ff @(posedge clock) begin
      if (rd_acc[p]) pipe_d[0] <= mem[addr[p]];
      for (int k = 1; k < RD_LAT; k++) pipe_d[k] <= pipe_d[k-1];
    end

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        pipe_v <= '0;
        q_r    <= '0;
        qv_r   <= 1'b0;
      end else begin
        pipe_v[0] <= rd_acc[p];
        for (int k = 1; k < RD_LAT; k++) pipe_v[k] <= pipe_v[k-1];
        qv_r <= pipe_v[RD_LAT-1];
        if (pipe_v[RD_LAT-1]) q_r <= pipe_d[RD_LAT-1];
      end
    end
  end

  assign q_a       = g_port[0].q_r;
  assign q_valid_a = g_port[0].qv_r;
  assign q_b       = g_port[1].q_r;
  assign q_valid_b = g_port[1].qv_r;

endmodule

// File: tb/tb_ram_2rw_clr.sv
// Directed bench for ram_2rw_clr: clear sequencing, byte lanes, port collisions,
// read latency/throughput and reset behaviour.
module tb_ram_2rw_clr;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 4;
  localparam int unsigned LAT = 2;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          clear_req;
  logic          init_done;
  logic          en_a, wr_en_a, en_b, wr_en_b;
  logic [AW-1:0] address_a, address_b;
  logic [DW-1:0] wr_data_a, wr_data_b;
  logic [7:0]    be_a, be_b;
  logic [DW-1:0] q_a, q_b;
  logic          q_valid_a, q_valid_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  ram_2rw_clr #(
    .DWIDTH(64), .AWIDTH(4), .BWIDTH(8), .RD_LAT(2), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .rst_n(rst_n), .clear_req(clear_req), .init_done(init_done),
    .en_a(en_a), .wr_en_a(wr_en_a), .address_a(address_a), .wr_data_a(wr_data_a),
    .be_a(be_a), .q_a(q_a), .q_valid_a(q_valid_a),
    .en_b(en_b), .wr_en_b(wr_en_b), .address_b(address_b), .wr_data_b(wr_data_b),
    .be_b(be_b), .q_b(q_b), .q_valid_b(q_valid_b)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    clear_req = 1'b0;
    en_a = 1'b0; wr_en_a = 1'b0; address_a = '0; wr_data_a = '0; be_a = '0;
    en_b = 1'b0; wr_en_b = 1'b0; address_b = '0; wr_data_b = '0; be_b = '0;
  endtask

  // Single write, called at posedge+1; returns at posedge+1
  task automatic wr(input int p, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                    input logic [7:0] be);
    if (p == 0) begin en_a = 1'b1; wr_en_a = 1'b1; address_a = ad; wr_data_a = d; be_a = be; end
    else        begin en_b = 1'b1; wr_en_b = 1'b1; address_b = ad; wr_data_b = d; be_b = be; end
    @(posedge clock); #1;
    idle_inputs();
  endtask

  // Single read; reports data and number of edges after acceptance until q_valid
  task automatic rd(input int p, input logic [AW-1:0] ad, output logic [DW-1:0] d,
                    output int lat);
    if (p == 0) begin en_a = 1'b1; wr_en_a = 1'b0; address_a = ad; end
    else        begin en_b = 1'b1; wr_en_b = 1'b0; address_b = ad; end
    @(posedge clock); #1;
    idle_inputs();
    d = '0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      if ((p == 0) ? q_valid_a : q_valid_b) begin
        lat = i;
        d = (p == 0) ? q_a : q_b;
        break;
      end
    end
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (init_done) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    int n;
    logic [DW-1:0] d;
    int lat;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    total_cnt++;
    if (q_a !== '0 || q_b !== '0 || q_valid_a !== 1'b0 || q_valid_b !== 1'b0 || init_done !== 1'b0)
      $display("FAIL reset_outputs: q_a=%h q_b=%h qva=%b qvb=%b init_done=%b, required all 0",
               q_a, q_b, q_valid_a, q_valid_b, init_done);
    else pass_cnt++;
    @(posedge clock); #1;
    rst_n = 1'b1;
    wait_ready(n);
    total_cnt++;
    if (n !== 16) $display("FAIL clear_duration_reset: init_done after %0d edges, required 16", n);
    else pass_cnt++;
    for (int a = 0; a < 16; a++) begin
      rd(a % 2, 4'(a), d, lat);
      total_cnt++;
      if (lat !== int'(LAT) || d !== '0)
        $display("FAIL cleared_word_%0d: data=%h lat=%0d, required 0 lat %0d", a, d, lat, LAT);
      else pass_cnt++;
    end
  endtask

  task automatic test_byte_lanes();
    logic [DW-1:0] d;
    int lat;
    wr(0, 4'd3, 64'h1122334455667788, 8'hFF);
    wr(0, 4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    wr(0, 4'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    rd(1, 4'd3, d, lat);
    total_cnt++;
    if (d !== 64'h11223344AAAAAAAA) $display("FAIL byte_lanes: q_b=%h, required 11223344aaaaaaaa", d);
    else pass_cnt++;
    total_cnt++;
    if (lat !== int'(LAT)) $display("FAIL read_latency: %0d, required %0d", lat, LAT);
    else pass_cnt++;
  endtask

  task automatic test_read_before_write();
    logic [DW-1:0] d;
    int lat;
    wr(0, 4'd7, 64'h9, 8'hFF);
    en_a = 1'b1; wr_en_a = 1'b1; address_a = 4'd7; wr_data_a = 64'h5; be_a = 8'h01;
    en_b = 1'b1; wr_en_b = 1'b0; address_b = 4'd7;
    @(posedge clock); #1;
    idle_inputs();
    d = '0; lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      if (q_valid_b) begin lat = i; d = q_b; break; end
    end
    total_cnt++;
    if (d !== 64'h9 || lat !== int'(LAT))
      $display("FAIL read_before_write: q_b=%h lat=%0d, required 9 lat %0d", d, lat, LAT);
    else pass_cnt++;
    rd(1, 4'd7, d, lat);
    total_cnt++;
    if (d !== 64'h5) $display("FAIL read_after_write: q_b=%h, required 5", d);
    else pass_cnt++;
  endtask

  task automatic test_write_collision();
    logic [DW-1:0] d;
    int lat;
    en_a = 1'b1; wr_en_a = 1'b1; address_a = 4'd2; wr_data_a = 64'h0101010101010101; be_a = 8'h0F;
    en_b = 1'b1; wr_en_b = 1'b1; address_b = 4'd2; wr_data_b = 64'h0202020202020202; be_b = 8'hFF;
    @(posedge clock); #1;
    idle_inputs();
    rd(0, 4'd2, d, lat);
    total_cnt++;
    if (d !== 64'h0202020201010101) $display("FAIL write_collision: q_a=%h, required 0202020201010101", d);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ad_a [4];
    logic [AW-1:0] ad_b [4];
    logic [DW-1:0] ex_a [4];
    logic [DW-1:0] ex_b [4];
    wr(0, 4'd4, 64'h4444, 8'hFF);
    wr(1, 4'd5, 64'h5555, 8'hFF);
    wr(0, 4'd6, 64'h6666, 8'hFF);
    ad_a = '{4'd4, 4'd5, 4'd6, 4'd3};
    ex_a = '{64'h4444, 64'h5555, 64'h6666, 64'h11223344AAAAAAAA};
    ad_b = '{4'd6, 4'd5, 4'd4, 4'd2};
    ex_b = '{64'h6666, 64'h5555, 64'h4444, 64'h0202020201010101};
    en_a = 1'b1; wr_en_a = 1'b0; address_a = ad_a[0];
    en_b = 1'b1; wr_en_b = 1'b0; address_b = ad_b[0];
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (c >= 2) begin
        total_cnt++;
        if (q_valid_a !== 1'b1 || q_a !== ex_a[c-2])
          $display("FAIL b2b_a_%0d: qv=%b q=%h, required 1 %h", c-2, q_valid_a, q_a, ex_a[c-2]);
        else pass_cnt++;
        total_cnt++;
        if (q_valid_b !== 1'b1 || q_b !== ex_b[c-2])
          $display("FAIL b2b_b_%0d: qv=%b q=%h, required 1 %h", c-2, q_valid_b, q_b, ex_b[c-2]);
        else pass_cnt++;
      end
      if (c + 1 < 4) begin
        address_a = ad_a[c+1];
        address_b = ad_b[c+1];
      end else idle_inputs();
    end
    @(posedge clock); #1;
    total_cnt++;
    if (q_valid_a !== 1'b0 || q_a !== 64'h11223344AAAAAAAA)
      $display("FAIL hold_between_strobes: qv=%b q_a=%h, required 0 11223344aaaaaaaa", q_valid_a, q_a);
    else pass_cnt++;
  endtask

  task automatic test_clear_req();
    int n;
    bit saw_a;
    bit saw_b;
    logic [DW-1:0] db;
    logic [DW-1:0] d;
    int lat;
    saw_a = 1'b0; saw_b = 1'b0; db = '0; n = -1;
    clear_req = 1'b1;
    en_b = 1'b1; wr_en_b = 1'b0; address_b = 4'd3;
    @(posedge clock); #1;
    idle_inputs();
    en_a = 1'b1; wr_en_a = 1'b0; address_a = 4'd4;
    for (int i = 1; i <= 100; i++) begin
      clear_req = (i == 5);
      @(posedge clock); #1;
      if (q_valid_a) saw_a = 1'b1;
      if (q_valid_b) begin saw_b = 1'b1; db = q_b; end
      if (init_done) begin n = i; break; end
    end
    idle_inputs();
    total_cnt++;
    if (n !== 16) $display("FAIL clear_duration_req: init_done after %0d edges, required 16", n);
    else pass_cnt++;
    total_cnt++;
    if (!saw_b || db !== 64'h11223344AAAAAAAA)
      $display("FAIL inflight_before_clear: seen=%0d q_b=%h, required 1 11223344aaaaaaaa", saw_b, db);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (q_valid_a) saw_a = 1'b1;
    end
    total_cnt++;
    if (saw_a) $display("FAIL read_during_clear: q_valid_a pulsed, required none");
    else pass_cnt++;
    for (int a = 0; a < 16; a++) begin
      rd(1, 4'(a), d, lat);
      total_cnt++;
      if (lat !== int'(LAT) || d !== '0)
        $display("FAIL recleared_word_%0d: data=%h lat=%0d, required 0", a, d, lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    logic [DW-1:0] d;
    int lat;
    wr(0, 4'd1, 64'hDEADBEEF, 8'hFF);
    rd(0, 4'd1, d, lat);
    rd(1, 4'd1, d, lat);
    clear_req = 1'b1;
    @(posedge clock); #1;
    clear_req = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clock); #1; end
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (q_a !== '0 || q_b !== '0 || init_done !== 1'b0)
      $display("FAIL reset_mid_clear_outputs: q_a=%h q_b=%h init_done=%b, required 0 0 0", q_a, q_b, init_done);
    else pass_cnt++;
    @(posedge clock); @(posedge clock); #1;
    rst_n = 1'b1;
    wait_ready(n);
    total_cnt++;
    if (n !== 16) $display("FAIL clear_restart: init_done after %0d edges, required 16", n);
    else pass_cnt++;
  endtask

  task automatic test_reset_inflight();
    int n;
    bit saw;
    saw = 1'b0;
    wr(0, 4'd8, 64'h8888, 8'hFF);
    en_a = 1'b1; wr_en_a = 1'b0; address_a = 4'd8;
    @(posedge clock); #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    if (q_valid_a) saw = 1'b1;
    @(posedge clock); #1;
    if (q_valid_a) saw = 1'b1;
    rst_n = 1'b1;
    wait_ready(n);
    if (q_valid_a) saw = 1'b1;
    total_cnt++;
    if (saw) $display("FAIL reset_discards_read: q_valid_a pulsed, required none");
    else pass_cnt++;
    total_cnt++;
    if (n !== 16) $display("FAIL clear_after_reset2: init_done after %0d edges, required 16", n);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_read_before_write();
    test_write_collision();
    test_back_to_back();
    test_clear_req();
    test_reset_mid_clear();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
